// File: rtl/pcileech_mux_rr_if.sv
// Source-side bus of the frame packer: per-port write/request lanes plus the framed output.
// The mux takes the slave modport; the producer/consumer side takes master.
interface pcileech_mux_rr_if #(
    parameter int unsigned FRAME_WORDS = 7
);
    logic [3:0][31:0]                  din;
    logic [3:0][1:0]                   ctx;
    logic [3:0]                        wr_en;
    logic [3:0]                        has_data;
    logic [3:0]                        req_data;
    logic                              rd_en;
    logic                              flush;
    logic [32*(FRAME_WORDS+1)-1:0]     dout;
    logic                              valid;

    modport master (
        output din, ctx, wr_en, has_data, rd_en, flush,
        input  req_data, dout, valid
    );

    modport slave (
        input  din, ctx, wr_en, has_data, rd_en, flush,
        output req_data, dout, valid
    );
endinterface

// File: rtl/pcileech_mux_rr.sv
// Merges up to four 32-bit source streams into status+data frames for the FT601 path,
// with fixed/round-robin request arbitration, idle-timeout fill, flush and counters.
module pcileech_mux_rr #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned FRAME_WORDS = 7,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pcileech_mux_rr_if.slave        bus,
    output logic [15:0]             o_collision_cnt,
    output logic [31:0]             o_frame_cnt
);
    localparam int unsigned DW       = 32 * (FRAME_WORDS + 1);
    localparam logic [2:0]  FillLast = 3'(FRAME_WORDS - 1);
    localparam logic [7:0]  IdleMax  = 8'(TIMEOUT);
    localparam logic [3:0]  PortMask = 4'((1 << NUM_PORTS) - 1);

    logic [3:0]    r_req;
    logic [1:0]    r_rr_ptr;
    logic [2:0]    r_fill;
    logic [7:0]    r_idle;
    logic [31:0]   r_data [FRAME_WORDS];
    logic [3:0]    r_tag  [FRAME_WORDS];
    logic [DW-1:0] r_stage;
    logic          r_stage_vld;
    logic [DW-1:0] r_dout;
    logic          r_valid;
    logic [15:0]   r_coll;
    logic [31:0]   r_frames;

    logic [3:0]    w_req_pend;
    logic [3:0]    w_grant;
    logic [1:0]    w_grant_idx;
    logic          w_grant_vld;
    logic [1:0]    w_idx;
    logic [1:0]    w_ptr_nxt;
    logic [3:0]    w_wr;
    logic          w_acc_vld;
    logic [1:0]    w_acc_idx;
    logic [2:0]    w_drops;
    logic          w_fill_nz;
    logic          w_word_vld;
    logic [31:0]   w_word_data;
    logic [3:0]    w_word_tag;
    logic          w_last;
    logic [31:0]   w_status;
    logic [DW-1:0] w_frame;
    logic [16:0]   w_coll_sum;

    // Scan order starts at rr_ptr in round-robin mode, at port 0 in fixed mode.
    always_comb begin
        w_req_pend  = bus.has_data & PortMask & {4{bus.rd_en}};
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            w_idx = (ARB_MODE != 0) ? 2'((int'(r_rr_ptr) + k) % int'(NUM_PORTS)) : 2'(k);
            if (!w_grant_vld && w_req_pend[w_idx]) begin
                w_grant_vld    = 1'b1;
                w_grant_idx    = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
        w_ptr_nxt = 2'((int'(w_grant_idx) + 1) % int'(NUM_PORTS));
    end

    always_comb begin
        w_wr      = bus.wr_en & PortMask;
        w_acc_vld = 1'b0;
        w_acc_idx = '0;
        w_drops   = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_wr[k]) begin
                if (!w_acc_vld) begin
                    w_acc_vld = 1'b1;
                    w_acc_idx = 2'(k);
                end else begin
                    w_drops = w_drops + 3'd1;
                end
            end
        end
        w_coll_sum = {1'b0, r_coll} + 17'(w_drops);
    end

    // A real write always beats filler; filler only pads an already-started frame.
    always_comb begin
        w_fill_nz   = (r_fill != 3'd0);
        w_word_vld  = w_acc_vld | (w_fill_nz & ((r_idle >= IdleMax) | bus.flush));
        w_word_data = w_acc_vld ? bus.din[w_acc_idx] : 32'hFFFF_FFFF;
        w_word_tag  = w_acc_vld ? {bus.ctx[w_acc_idx], w_acc_idx} : 4'hF;
        w_last      = w_word_vld & (r_fill == FillLast);

        w_status        = '1;
        w_status[3:0]   = 4'hE;
        w_status[7:4]   = w_word_tag;
        w_frame         = '0;
        w_frame[31:0]   = w_word_data;
        for (int k = 1; k < int'(FRAME_WORDS); k++) begin
            w_status[4*k+4 +: 4] = r_tag[k-1];
            w_frame[32*k +: 32]  = r_data[k-1];
        end
        w_frame[DW-1 -: 32] = w_status;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= '0;
            r_rr_ptr    <= '0;
            r_fill      <= '0;
            r_idle      <= '0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_coll      <= '0;
            r_frames    <= '0;
            for (int k = 0; k < int'(FRAME_WORDS); k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= 4'hF;
            end
        end else begin
            r_req <= w_grant;
            if ((ARB_MODE != 0) && w_grant_vld) begin
                r_rr_ptr <= w_ptr_nxt;
            end

            if (w_word_vld) begin
                r_data[0] <= w_word_data;
                r_tag[0]  <= w_word_tag;
                for (int k = 1; k < int'(FRAME_WORDS); k++) begin
                    r_data[k] <= r_data[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end

            // idle_cnt survives accepted writes; only frame completion clears it.
            if (w_last) begin
                r_fill      <= '0;
                r_idle      <= '0;
                r_stage     <= w_frame;
                r_stage_vld <= 1'b1;
                r_frames    <= r_frames + 32'd1;
            end else begin
                r_stage_vld <= 1'b0;
                if (w_word_vld) begin
                    r_fill <= r_fill + 3'd1;
                end
                if (w_fill_nz && !w_acc_vld && (r_idle < IdleMax)) begin
                    r_idle <= r_idle + 8'd1;
                end
            end

            r_valid <= r_stage_vld;
            if (r_stage_vld) begin
                r_dout <= r_stage;
            end

            r_coll <= w_coll_sum[16] ? 16'hFFFF : w_coll_sum[15:0];
        end
    end

    assign bus.req_data    = r_req;
    assign bus.dout        = r_dout;
    assign bus.valid       = r_valid;
    assign o_collision_cnt = r_coll;
    assign o_frame_cnt     = r_frames;
endmodule

// File: doc/pcileech_mux_rr.md
# pcileech_mux_rr

Parametrised successor to the four-port 256-bit packer. It merges up to four 32-bit source streams into frames of one status word plus FRAME_WORDS data words for the FT601 path. It adds selectable fixed-priority or round-robin arbitration, a programmable partial-frame timeout, an explicit flush input, and collision/frame counters. It sits between the per-source FIFOs (PCIe TLP, config, loopback, command) and the FT601 transmit FIFO.

## Interface
- NUM_PORTS, 4, active ports, 1..4; ports ≥ NUM_PORTS are ignored and their req_data is held 0
- FRAME_WORDS, 7, data words per frame, 1..7; dout width = 32*(FRAME_WORDS+1)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 8, idle cycles before filler insertion into a partial frame, 1..255
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dout  out  32*(FRAME_WORDS+1)  frame: status word in top 32 bits, slot k at [32k+31:32k]
- valid  out  1  one-cycle frame strobe
- rd_en  in  1  downstream not almost-full; gates requests only
- flush  in  1  force completion of a partial frame with filler
- pN_din  in  32  port N data, N = 0..3
- pN_ctx  in  2  port N context tag
- pN_wr_en  in  1  port N word strobe
- pN_has_data  in  1  port N source non-empty
- pN_req_data  out  1  registered read request to port N source
- collision_cnt  out  16  saturating count of dropped simultaneous writes
- frame_cnt  out  32  wrapping count of emitted frames

## Operation
- Request, fixed mode: req_data[i] <= rd_en & has_data[i] & no has_data[j<i]. At most one req high per cycle.
- Request, round-robin mode: search starts at rr_ptr. The first requesting port at or after rr_ptr (wrapping) gets req. On each grant, rr_ptr <= granted+1 mod NUM_PORTS. rr_ptr is unchanged when no grant is issued.
- Accept: the lowest-index asserted wr_en is accepted. Every additionally asserted wr_en that cycle is dropped and adds 1 to collision_cnt (saturating at 16'hFFFF). A source FIFO honouring req_data never collides.
- Packing:
  - Accepted word shifts in at slot 0; older words move up one slot.
  - Tag = {ctx[1:0], port[1:0]} shifts in at status nibble 1.
  - Status word: bits [3:0] = 4'hE marker; bits [4k+7:4k+4] = tag of slot k; nibbles for k ≥ FRAME_WORDS = 4'hF.
- Filler:
  - Data 32'hFFFFFFFF, tag 4'hF.
  - Inserted in any cycle with no accepted write when fill_count > 0 and either (idle_cnt ≥ TIMEOUT) or flush.
  - flush with fill_count = 0 has no effect.
- Counters:
  - fill_count (0..FRAME_WORDS-1) increments on each accepted or filler word.
  - On the word that makes FRAME_WORDS, fill_count <= 0, idle_cnt <= 0, a frame is staged, and frame_cnt increments.
  - idle_cnt increments (saturating at TIMEOUT) each cycle with fill_count > 0 and no accepted write. An accepted write does not clear idle_cnt; only frame completion clears it.
- Frames are emitted regardless of rd_en. Downstream must absorb up to 2 frames beyond rd_en deassertion.

## Timing
- Reset values: dout = 0, valid = 0, all req_data = 0, collision_cnt = 0, frame_cnt = 0, fill_count = 0, idle_cnt = 0, rr_ptr = 0, shift tags = 4'hF.
- Reset takes effect at the next edge. A partial frame is discarded without emission.
- Request latency: 1 cycle from has_data/rd_en to req_data.
- Frame latency: final word sampled at edge E; staged at E; dout/valid registered at E+1; valid high for exactly one cycle.
- Back-to-back frames: possible every FRAME_WORDS cycles. With FRAME_WORDS = 1, possible every cycle.
- The write for a new frame may occur in the cycle valid is high; it does not disturb dout.
- flush and wr_en in the same cycle: the write wins; flush is re-evaluated the next cycle.

## Test plan
- Fixed mode, 4 ports, FRAME_WORDS = 7; port 2 writes 7 words 0x10..0x16 with ctx = 1 -> one valid pulse 2 cycles after the last write; slot 0 = 0x16, slot 6 = 0x10; status = 32'h6666666E.
- Round-robin mode; ports 0 and 3 both has_data with rd_en = 1 for 6 cycles -> req alternates 0,3,0,3,0,3. Fixed mode with the same stimulus -> port 0 only.
- 3 words written, then idle, TIMEOUT = 8 -> fillers begin on the 9th idle cycle; frame has 4 × 32'hFFFFFFFF in slots 0..3 and status nibbles 1..4 = F.
- 2 words written, flush pulsed one cycle later and held -> 5 fillers in consecutive cycles; valid follows. flush with an empty frame -> no valid.
- p0 and p1 wr_en together for 3 cycles -> only p0 words packed; collision_cnt = 3.
- rst asserted mid-frame after 4 words, then 7 new words -> exactly one frame containing only the new words; frame_cnt = 1.
